spi_master: RTL and testbench

SPI initiator that runs single-byte read and write transactions against the on-board SPI memory slave. It drives chip select, SCLK and MOSI, and captures MISO. It converts a one-cycle `start` request with address, direction and data into a 16-bit frame: 7-bit address, R/W bit, then 8 data bits. It is the host-side counterpart of the SPI memory, and it is also the stimulus engine for loopback tests on the FPGA.

---
 rtl/spi_master_pkg.sv | 13 +
 rtl/spi_master_if.sv | 13 +
 rtl/spi_phase_timer.sv | 16 +
 rtl/spi_master.sv | 81 ++++++++
 tb/tb_spi_master.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/spi_master_pkg.sv
// spi_master_pkg: frame widths, R/W encoding, FSM states and frame packing
package spi_master_pkg;
    localparam int SPI_ADDR_W = 7;
    localparam int SPI_DATA_W = 8;
    localparam int SPI_FRAME_W = 16;
    localparam logic RW_READ = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TAIL, GAP} state_t;
    function automatic logic [SPI_FRAME_W-1:0] mk_frame(
        input logic [SPI_ADDR_W-1:0] a, input logic r, input logic [SPI_DATA_W-1:0] d);
        return {a, r, r == RW_WRITE ? d : 8'h00};
    endfunction
endpackage

// File: rtl/spi_master_if.sv
// spi_master_if: host-side request/response bundle of the SPI initiator
interface spi_master_if;
    import spi_master_pkg::*;
    logic start;
    logic rw;
    logic [SPI_ADDR_W-1:0] addr;
    logic [SPI_DATA_W-1:0] wdata;
    logic busy;
    logic done;
    logic [SPI_DATA_W-1:0] rdata;
    modport master(output start, rw, addr, wdata, input busy, done, rdata);
    modport slave(input start, rw, addr, wdata, output busy, done, rdata);
endinterface

// File: rtl/spi_phase_timer.sv
// spi_phase_timer: CLK_DIV-cycle down-counter ticking phase_end on each phase's last cycle
module spi_phase_timer #(
    parameter int CLK_DIV = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic phase_end
);
    localparam int W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge reset)
        if (!reset) cnt <= '0;
        else cnt <= (restart || cnt == '0) ? W'(CLK_DIV - 1) : cnt - 1'b1;
    assign phase_end = !restart && cnt == '0;
endmodule

// File: rtl/spi_master.sv
// spi_master: single-byte SPI read/write initiator (CPOL=0, MSB first, 16-bit frame)
module spi_master
    import spi_master_pkg::*;
#(
    parameter int CLK_DIV = 8,
    parameter int GAP_HALVES = 2
) (
    input  logic clk,
    input  logic reset,
    spi_master_if.slave bus,
    output logic cs_pin,
    output logic sclk_pin,
    output logic mosi_pin,
    input  logic miso_pin
);
    state_t state, state_n;
    logic pe, accept, last_ph, shift_en, sample_en;
    logic [4:0] ph, ph_d;
    logic [SPI_FRAME_W-1:0] shreg, shreg_d;
    logic [SPI_DATA_W-1:0] cap, cap_d, rdata_d;
    logic rw_q, cs_d, sclk_d, busy_d, done_d;

    spi_phase_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk(clk), .reset(reset), .restart(state == IDLE), .phase_end(pe)
    );

    assign accept = state == IDLE && bus.start;
    assign last_ph = pe && ph == (state == SHIFT ? 5'd31 : 5'(GAP_HALVES - 1));
    assign mosi_pin = shreg[SPI_FRAME_W-1];

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state <= IDLE;
            ph <= '0;
            shreg <= '0;
            cap <= '0;
            rw_q <= 1'b0;
            cs_pin <= 1'b1;
            sclk_pin <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.rdata <= '0;
        end else begin
            state <= state_n;
            ph <= ph_d;
            shreg <= shreg_d;
            cap <= cap_d;
            rw_q <= accept ? bus.rw : rw_q;
            cs_pin <= cs_d;
            sclk_pin <= sclk_d;
            bus.busy <= busy_d;
            bus.done <= done_d;
            bus.rdata <= rdata_d;
        end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = bus.start ? LEAD : IDLE;
            LEAD:    state_n = pe ? SHIFT : LEAD;
            SHIFT:   state_n = last_ph ? TAIL : SHIFT;
            TAIL:    state_n = pe ? GAP : TAIL;
            GAP:     state_n = last_ph ? IDLE : GAP;
            default: state_n = IDLE;
        endcase
    end

    // even SHIFT phases are SCLK-high; data moves on at the end of each high phase
    always_comb begin
        shift_en = state == SHIFT && pe && !ph[0];
        sample_en = shift_en && ph[4];
        ph_d = state_n != state ? 5'd0 : pe ? ph + 5'd1 : ph;
        shreg_d = accept ? mk_frame(bus.addr, bus.rw, bus.wdata) : shift_en ? shreg << 1 : shreg;
        cap_d = sample_en ? {cap[SPI_DATA_W-2:0], miso_pin} : cap;
        cs_d = accept ? 1'b0 : (state == TAIL && pe) ? 1'b1 : cs_pin;
        sclk_d = state_n == SHIFT && (state == LEAD || (pe ? ph[0] : sclk_pin));
        done_d = state == TAIL && pe;
        busy_d = accept || (bus.busy && !(state == GAP && last_ph));
        rdata_d = (done_d && rw_q == RW_READ) ? cap : bus.rdata;
    end
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: table, directed and random checks of spi_master against a memory slave model
module tb_spi_master;
    localparam int C = 4;
    localparam int G = 2;
    localparam int SP = (34 + G) * C + 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic cs_pin, sclk_pin, mosi_pin;
    logic miso = 1'b0;
    int cyc = 0;
    int pass_cnt = 0, total_cnt = 0;

    spi_master_if bus();
    spi_master #(.CLK_DIV(C), .GAP_HALVES(G)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .cs_pin(cs_pin), .sclk_pin(sclk_pin), .mosi_pin(mosi_pin), .miso_pin(miso)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // behavioural SPI memory on the pins
    logic [7:0] slave_mem [128];
    logic [15:0] rx = '0;
    logic [15:0] last_frame = '0;
    logic [6:0] s_addr = '0;
    logic s_rw = 1'b0;
    int nb = 0;
    int frames = 0;

    always @(negedge cs_pin) begin
        nb = 0;
        rx = '0;
    end
    always @(posedge sclk_pin) if (!cs_pin) begin
        rx = {rx[14:0], mosi_pin};
        nb++;
        if (nb == 8) begin
            s_addr = rx[7:1];
            s_rw = rx[0];
        end
    end
    always @(negedge sclk_pin) if (!cs_pin && nb >= 8 && nb < 16 && s_rw) begin
        logic [7:0] b;
        b = slave_mem[s_addr];
        miso = b[15 - nb];
    end
    always @(posedge cs_pin) if (nb == 16) begin
        if (!s_rw) slave_mem[s_addr] = rx[7:0];
        last_frame = rx;
        frames++;
        nb = 0;
    end

    // reference: memory contents and the rdata register as the spec describes them
    logic [7:0] model_mem [128];
    logic [7:0] exp_rd = 8'h00;

    typedef struct {
        logic rw;
        logic [6:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 2000) begin
            n++;
            @(negedge clk);
        end
        if (n >= 2000) chk("idle timeout", 0, 1);
    endtask

    task automatic xfer(input logic r, input logic [6:0] a, input logic [7:0] d,
                        input logic [7:0] exp, input int inject, input string nm);
        int n, gap, dn, fr0;
        logic [15:0] exp_fr;
        exp_fr = {a, r, r ? 8'h00 : d};
        wait_idle();
        fr0 = frames;
        bus.start = 1'b1; bus.rw = r; bus.addr = a; bus.wdata = d;
        @(negedge clk);
        bus.start = 1'b0; bus.rw = ~r; bus.addr = ~a; bus.wdata = ~d;
        chk({nm, " cs after accept"}, cs_pin, 0);
        chk({nm, " busy after accept"}, bus.busy, 1);
        chk({nm, " first mosi"}, mosi_pin, a[6]);
        n = 0; dn = 0;
        while (!cs_pin && n < 2000) begin
            if (n == inject) begin bus.start = 1'b1; bus.addr = 7'h01; bus.rw = 1'b1; end
            if (n == inject + 1) bus.start = 1'b0;
            if (bus.done) dn++;
            n++;
            @(negedge clk);
        end
        chk({nm, " cs low cycles"}, n, 34 * C);
        chk({nm, " done early"}, dn, 0);
        chk({nm, " done at cs rise"}, bus.done, 1);
        chk({nm, " rdata"}, bus.rdata, exp);
        @(negedge clk);
        chk({nm, " done one cycle"}, bus.done, 0);
        gap = 1;
        while (bus.busy && gap < 2000) begin
            gap++;
            @(negedge clk);
        end
        chk({nm, " busy tail"}, gap, G * C);
        chk({nm, " frame count"}, frames - fr0, 1);
        chk({nm, " frame bits"}, last_frame, exp_fr);
        if (!r) model_mem[a] = d;
        else exp_rd = exp;
    endtask

    vec_t vt[9];
    int falls[3], rises[3];
    int nf, nr, fr0, n;
    logic pcs, r;
    logic [6:0] a;
    logic [7:0] d;

    initial begin
        vt[0] = '{1'b0, 7'h2A, 8'hA5, 8'h00};
        vt[1] = '{1'b0, 7'h2A, 8'h3C, 8'h00};
        vt[2] = '{1'b1, 7'h2A, 8'h00, 8'h3C};
        vt[3] = '{1'b0, 7'h10, 8'h5A, 8'h3C};
        vt[4] = '{1'b0, 7'h11, 8'hC3, 8'h3C};
        vt[5] = '{1'b1, 7'h10, 8'h00, 8'h5A};
        vt[6] = '{1'b1, 7'h11, 8'h00, 8'hC3};
        vt[7] = '{1'b0, 7'h7F, 8'hFF, 8'hC3};
        vt[8] = '{1'b1, 7'h7F, 8'h00, 8'hFF};
        for (int i = 0; i < 128; i++) begin
            slave_mem[i] = 8'(i) ^ 8'h5A;
            model_mem[i] = 8'(i) ^ 8'h5A;
        end
        bus.start = 1'b0; bus.rw = 1'b0; bus.addr = '0; bus.wdata = '0;
        repeat (3) @(negedge clk);
        chk("reset cs", cs_pin, 1);
        chk("reset sclk", sclk_pin, 0);
        chk("reset mosi", mosi_pin, 0);
        chk("reset busy", bus.busy, 0);
        chk("reset done", bus.done, 0);
        chk("reset rdata", bus.rdata, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 9; i++) xfer(vt[i].rw, vt[i].addr, vt[i].wdata, vt[i].exp, -1, $sformatf("vec%0d", i));

        // start pulsed mid-frame must neither alter nor queue a frame
        fr0 = frames;
        xfer(1'b0, 7'h05, 8'h11, exp_rd, 20, "busy_rej");
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!cs_pin) n++;
        end
        chk("busy_rej no second frame", n + frames - fr0, 1);

        // abort a write mid-frame, the aborted write must not land
        xfer(1'b1, 7'h10, 8'h00, 8'h5A, -1, "pre_abort");
        bus.start = 1'b1; bus.rw = 1'b0; bus.addr = 7'h10; bus.wdata = 8'h77;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (nb < 9 && n < 2000) begin
            n++;
            @(negedge clk);
        end
        chk("abort reached bit 9", nb, 9);
        #1 reset = 1'b0;
        #1;
        chk("abort cs", cs_pin, 1);
        chk("abort sclk", sclk_pin, 0);
        chk("abort done", bus.done, 0);
        chk("abort busy", bus.busy, 0);
        chk("abort rdata", bus.rdata, 0);
        exp_rd = 8'h00;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort no done", bus.done, 0);
        xfer(1'b0, 7'h12, 8'h99, 8'h00, -1, "post_abort");
        xfer(1'b1, 7'h10, 8'h00, 8'h5A, -1, "abort_no_write");

        // start held high: frames back to back
        fr0 = frames;
        bus.rw = 1'b0; bus.addr = 7'h20; bus.wdata = 8'h33; bus.start = 1'b1;
        nf = 0; nr = 0; pcs = 1'b1;
        for (int i = 0; i < 2000 && nf < 3; i++) begin
            @(negedge clk);
            if (pcs && !cs_pin) begin falls[nf] = cyc; nf++; end
            if (!pcs && cs_pin && nr < 3) begin rises[nr] = cyc; nr++; end
            pcs = cs_pin;
        end
        bus.start = 1'b0;
        chk("b2b falls", nf, 3);
        chk("b2b spacing 1", falls[1] - falls[0], SP);
        chk("b2b spacing 2", falls[2] - falls[1], SP);
        chk("b2b cs high gap", (falls[1] - rises[0]) >= G * C, 1);
        @(negedge clk);
        wait_idle();
        chk("b2b frames", frames - fr0, 3);
        chk("b2b frame bits", last_frame, {7'h20, 1'b0, 8'h33});
        chk("b2b rdata kept", bus.rdata, exp_rd);
        model_mem[7'h20] = 8'h33;

        for (int i = 0; i < 12; i++) begin
            r = 1'($urandom_range(0, 1));
            a = 7'h40 + 7'($urandom_range(0, 3));
            d = 8'($urandom);
            xfer(r, a, d, r ? model_mem[a] : exp_rd, -1, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
